// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Shared encodings for the EX stage: aluop codes, funct codes,         |
// | internal ALU operations, EX FSM states and control-field positions.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_pkg;

  // aluop field from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  // Internal ALU operations
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_MFHI  = 3'd5,
    ALU_MFLO  = 3'd6,
    ALU_MULTU = 3'd7
  } alu_op_e;

  // EX-stage multiply sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // WB control {regwrite, memtoreg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  // M control {branch, memread, memwrite}
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  // EX control {regdst, aluop[1:0], alusrc}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  // A multu leaving EX must not write the register file or touch memory;
  // only memtoreg and branch survive.
  localparam logic [1:0] WB_MULTU_KEEP = 2'b01;
  localparam logic [2:0] M_MULTU_KEEP  = 3'b100;

  function automatic alu_op_e alu_control(input logic [1:0] aluop,
                                          input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    if (aluop == ALUOP_SUB) begin
      op = ALU_SUB;
    end else if (aluop == ALUOP_FUNCT) begin
      case (funct)
        FUNCT_SUB:   op = ALU_SUB;
        FUNCT_AND:   op = ALU_AND;
        FUNCT_OR:    op = ALU_OR;
        FUNCT_SLT:   op = ALU_SLT;
        FUNCT_MFHI:  op = ALU_MFHI;
        FUNCT_MFLO:  op = ALU_MFLO;
        FUNCT_MULTU: op = ALU_MULTU;
        default:     op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_seq                                                             |
// | Sequential shift-add unsigned multiplier, one bit per cycle.         |
// | Ports: clk, rst (async, active-high); start loads a/b; hold freezes; |
// | abort cancels; busy while iterating; done pulses (combinational) in  |
// | the cycle whose edge completes the last step; product is the value   |
// | the accumulator takes at that edge, valid while done is high.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  // Upper half accumulates partial sums; lower half starts as the
  // multiplier and is shifted out one bit per step.
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               running;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {partial, acc[WIDTH-1:1]};
  end

  assign busy    = running;
  assign done    = running && !hold && !abort && (count == LAST);
  assign product = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (!hold) begin
      if (start) begin
        mcand   <= a;
        acc     <= {{WIDTH{1'b0}}, b};
        count   <= '0;
        running <= 1'b1;
      end else if (running) begin
        acc   <= acc_next;
        count <= count + CW'(1);
        if (count == LAST) begin
          running <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_mem_stage                                                         |
// | EXECUTE stage plus EX/MEM pipeline register, with a sequential MULTU |
// | unit writing HI/LO.                                                  |
// | Inputs : ID/EX outputs (id_valid, wb/m/ex control, npc, rs, rt,      |
// |          sign-extended immediate, rt/rd fields), mem_stall, flush.   |
// | Outputs: ex_stall to ID/EX; registered EX/MEM fields (wb_ctl, m_ctl, |
// |          add_result, zero, alu_result, rdata2, dest_reg, ex_valid);  |
// |          hi, lo.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic [3:0]  ex_ctlout,
  input  logic [31:0] npcout,
  input  logic [31:0] rdata1out,
  input  logic [31:0] rdata2out,
  input  logic [31:0] s_extendout,
  input  logic [4:0]  instrout_2016,
  input  logic [4:0]  instrout_1511,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        ex_stall,
  output logic [1:0]  wb_ctl,
  output logic [2:0]  m_ctl,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2,
  output logic [4:0]  dest_reg,
  output logic        ex_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  alu_op_e     op;
  logic        is_multu;
  logic [31:0] opb;
  logic [31:0] alu_out;
  logic [4:0]  dest_sel;
  logic [31:0] branch_target;

  ex_state_e   state;
  ex_state_e   state_next;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_product;
  logic        load_instr;
  logic        load_multu;

  // ------------------------------------------------------------------
  // Execute datapath
  // ------------------------------------------------------------------
  assign op            = alu_control(ex_ctlout[EX_ALUOP_HI:EX_ALUOP_LO], s_extendout[5:0]);
  assign is_multu      = id_valid && (op == ALU_MULTU);
  assign opb           = ex_ctlout[EX_ALUSRC] ? s_extendout : rdata2out;
  assign dest_sel      = ex_ctlout[EX_REGDST] ? instrout_1511 : instrout_2016;
  assign branch_target = npcout + {s_extendout[29:0], 2'b00};

  always_comb begin
    alu_out = rdata1out + opb;
    case (op)
      ALU_SUB:  alu_out = rdata1out - opb;
      ALU_AND:  alu_out = rdata1out & opb;
      ALU_OR:   alu_out = rdata1out | opb;
      ALU_SLT:  alu_out = {31'b0, $signed(rdata1out) < $signed(opb)};
      ALU_MFHI: alu_out = hi;
      ALU_MFLO: alu_out = lo;
      default:  ;
    endcase
  end

  // ------------------------------------------------------------------
  // Multiply sequencing
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ex_stall   = 1'b0;
    mul_start  = 1'b0;
    load_instr = 1'b0;
    load_multu = 1'b0;
    if (flush) begin
      // Squashed instruction: nothing to hold upstream, any multiply dies.
      state_next = ST_IDLE;
    end else if (mem_stall) begin
      ex_stall = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_multu) begin
            ex_stall   = 1'b1;
            mul_start  = 1'b1;
            state_next = ST_MUL;
          end else if (id_valid) begin
            load_instr = 1'b1;
          end
        end
        ST_MUL: begin
          ex_stall = 1'b1;
          if (mul_done) begin
            state_next = ST_DONE;
          end else if (!mul_busy) begin
            state_next = ST_IDLE;
          end
        end
        ST_DONE: begin
          // ID/EX still holds the multu; release it and retire it once.
          load_multu = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  mult_seq #(
    .WIDTH (MUL_CYCLES)
  ) u_mult_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .hold    (mem_stall),
    .abort   (flush),
    .a       (rdata1out),
    .b       (rdata2out),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // mul_done is already suppressed by flush and mem_stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_done) begin
      hi <= mul_product[63:32];
      lo <= mul_product[31:0];
    end
  end

  // ------------------------------------------------------------------
  // EX/MEM pipeline register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ctl     <= '0;
      m_ctl      <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2     <= '0;
      dest_reg   <= '0;
      ex_valid   <= 1'b0;
    end else if (flush || !mem_stall) begin
      // Under flush both load flags are low, so a bubble is loaded.
      if (load_instr || load_multu) begin
        wb_ctl     <= load_multu ? (wb_ctlout & WB_MULTU_KEEP) : wb_ctlout;
        m_ctl      <= load_multu ? (m_ctlout & M_MULTU_KEEP) : m_ctlout;
        add_result <= branch_target;
        zero       <= (alu_out == 32'd0);
        alu_result <= alu_out;
        rdata2     <= rdata2out;
        dest_reg   <= dest_sel;
        ex_valid   <= 1'b1;
      end else begin
        wb_ctl     <= '0;
        m_ctl      <= '0;
        add_result <= '0;
        zero       <= 1'b0;
        alu_result <= '0;
        rdata2     <= '0;
        dest_reg   <= '0;
        ex_valid   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
